// File: rtl/lotr_uart_tx.sv
// UART transmitter with a byte FIFO, 8N1 frames (8E1 when LOTR_UART_TX_PARITY_EN is defined).
// UartTx is registered from the FSM state, so the line trails the state by one QClk cycle.
module lotr_uart_tx #(
    parameter int CLKS_PER_BIT = 43,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       QClk,
    input  logic       RstQnnnL,
    input  logic [7:0] TxData,
    input  logic       TxValid,
    output logic       TxReady,
    output logic       UartTx,
    output logic       TxBusy,
    output logic [4:0] FifoCount
);

    // state     | meaning
    // ST_IDLE   | line high, waiting for a queued byte
    // ST_START  | start bit (0)
    // ST_DATA   | data bits D0..D7, LSB first
    // ST_PARITY | even parity bit (parity builds only)
    // ST_STOP   | stop bit (1); chains straight into the next frame if bytes are queued
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef LOTR_UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_TC  = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  FULL_CNT = 5'(FIFO_DEPTH);

    state_t          r_state;
    state_t          w_next_state;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [4:0]      r_count;
    logic            r_rdy_en;
    logic [15:0]     r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;
    logic            w_baud_tc;
    logic            w_tx_next;
    logic [7:0]      w_head;
`ifdef LOTR_UART_TX_PARITY_EN
    logic            r_par;
`endif

    assign w_empty   = (r_count == 5'd0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_baud_tc = (r_baud == BAUD_TC);

    // r_rdy_en keeps TxReady low while reset is held and for no longer.
    assign TxReady   = r_rdy_en & ~w_full;
    assign w_push    = TxValid & TxReady;
    assign UartTx    = r_tx;
    assign TxBusy    = (r_state != ST_IDLE) || !w_empty;
    assign FifoCount = r_count;

    always_ff @(posedge QClk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= TxData;
        end
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                w_tx_next = 1'b0;
                if (w_baud_tc) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                w_tx_next = r_shift[0];
                if (w_baud_tc && (r_bit == 3'd7)) begin
`ifdef LOTR_UART_TX_PARITY_EN
                    w_next_state = ST_PARITY;
`else
                    w_next_state = ST_STOP;
`endif
                end
            end
`ifdef LOTR_UART_TX_PARITY_EN
            ST_PARITY: begin
                w_tx_next = r_par;
                if (w_baud_tc) begin
                    w_next_state = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                w_tx_next = 1'b1;
                if (w_baud_tc) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = ST_START;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'hFF;
            r_tx    <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
            if ((r_state == ST_IDLE) || w_baud_tc) begin
                r_baud <= 16'd0;
            end else begin
                r_baud <= r_baud + 16'd1;
            end
            // bit index wraps 7 -> 0 on the last data bit boundary
            if (r_state != ST_DATA) begin
                r_bit <= 3'd0;
            end else if (w_baud_tc) begin
                r_bit <= r_bit + 3'd1;
            end
            if (w_pop) begin
                r_shift <= w_head;
            end else if ((r_state == ST_DATA) && w_baud_tc) begin
                r_shift <= {1'b1, r_shift[7:1]};
            end
        end
    end

`ifdef LOTR_UART_TX_PARITY_EN
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            r_par <= 1'b0;
        end else if (w_pop) begin
            r_par <= ^w_head;
        end
    end
`endif

endmodule

// File: doc/lotr_uart_tx.md
LOTR_UART_TX -- requirements
Module: lotr_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 43, the QClk cycles per serial bit (43 at 5 MHz gives about 115200 baud); legal values are 2 to 65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, the byte FIFO depth; it SHALL be a power of 2, from 2 to 16.
REQ-003 Port QClk: input, 1 bit, the single clock; all state is on its rising edge.
REQ-004 Port RstQnnnL: input, 1 bit, asynchronous active-low reset.
REQ-005 Port TxData: input, 8 bits, the byte to transmit.
REQ-006 Port TxValid: input, 1 bit, TxData is valid.
REQ-007 Port TxReady: output, 1 bit, the FIFO can accept a byte.
REQ-008 Port UartTx: output, 1 bit, the serial line; idle level is high.
REQ-009 Port TxBusy: output, 1 bit, a frame is in progress or the FIFO is non-empty.
REQ-010 Port FifoCount: output, 5 bits, the number of bytes currently queued.

Function
REQ-011 A byte SHALL be accepted on a rising edge where TxValid=1 and TxReady=1; no other condition accepts a byte.
REQ-012 TxReady SHALL equal (FifoCount != FIFO_DEPTH), driven from registered state only, with no combinational path from TxValid.
REQ-013 TxValid while TxReady=0 SHALL be ignored: no write and no error; the source holds the byte.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE transition: if the FIFO is non-empty, pop the head byte into the shift register and go to START; otherwise hold UartTx=1.
REQ-016 START transition: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA transition: drive 8 bits LSB first, each for CLKS_PER_BIT cycles, then go to PARITY if it is enabled, else to STOP.
REQ-018 STOP transition: drive 1 for CLKS_PER_BIT cycles; at the end, go to START with a pop if the FIFO is non-empty (no idle gap between frames), else go to IDLE.
REQ-019 UartTx SHALL be a registered output with no glitches.
REQ-020 When the FSM is IDLE and the FIFO is empty, UartTx SHALL fall exactly 2 cycles after the edge that accepts the byte (1 cycle to write the FIFO, 1 cycle to pop).
REQ-021 The baud counter SHALL count from 0 to CLKS_PER_BIT-1 and reload at every bit boundary; the bit counter SHALL count 0 to 7 in DATA.
REQ-022 A push and a pop on the same edge SHALL leave FifoCount unchanged and preserve data order.
REQ-023 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and full and empty SHALL be derived from FifoCount.
REQ-024 A push at FifoCount=FIFO_DEPTH-1 SHALL make TxReady=0 on the next cycle.
REQ-025 TxBusy SHALL equal (state != IDLE) || (FifoCount != 0).
REQ-026 TxData SHALL be sampled only at the accept edge; later changes to TxData SHALL NOT affect a queued or in-flight byte.

Reset
REQ-027 While RstQnnnL=0, the block SHALL asynchronously force: state=IDLE, UartTx=1, FifoCount=0, pointers=0, counters=0, TxBusy=0.
REQ-028 TxReady SHALL be 0 during reset and 1 from the first edge after deassertion.
REQ-029 A reset asserted mid-frame SHALL abort the frame immediately, drive UartTx=1 and discard all queued bytes.
REQ-030 Reset deassertion SHALL be synchronized to QClk externally; the block does not synchronize it.

Configuration
REQ-031 The compile macro LOTR_UART_TX_PARITY_EN SHALL control parity.
- Defined: the PARITY state SHALL be present, driving an even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles between D7 and stop; frame length is 11 bit-times.
- Undefined: the PARITY state and its logic SHALL be absent; frame length is 10 bit-times.

Verification
REQ-032 CLKS_PER_BIT=4, no parity: send 0x55 while IDLE -> UartTx falls 2 cycles after accept, then the bit sequence 0,1,0,1,0,1,0,1,0,1 with each bit 4 cycles long; TxBusy drops after 40 cycles.
REQ-033 Send 0xA5 then 0x3C back-to-back -> the second start bit begins on the cycle right after the first stop bit ends; data is LSB first (A5 = 1,0,1,0,0,1,0,1).
REQ-034 FIFO_DEPTH=8, hold TxValid=1 with bytes 0x00..0x09 while a frame is in progress -> TxReady=0 when FifoCount=8, the held byte is not lost, and all 10 bytes go out in order.
REQ-035 Assert reset mid-DATA of byte 0xFF with 3 bytes queued -> UartTx=1 in the same cycle, FifoCount=0, no further frames appear.
REQ-036 With LOTR_UART_TX_PARITY_EN defined, send 0x07 -> the parity bit is 1 and the frame is 44 cycles long; send 0x03 -> the parity bit is 0.
REQ-037 At FifoCount=8, present TxValid=1 on the same edge the FSM pops -> the push is rejected (TxReady was 0) and FifoCount becomes 7.
